// File: rtl/addend_align_stage_pkg.sv
// rtl/addend_align_stage_pkg.sv - shared FMA widths and the addend-align stage payload record.
package addend_align_stage_pkg;

  localparam int EXP_WIDTH   = 8;
  localparam int SIG_WIDTH   = 7;
  localparam int SHAMT_WIDTH = 6;
  localparam int BIAS        = (1 << (EXP_WIDTH - 1)) - 1;
  localparam int ALIGN_WIDTH = 3 * SIG_WIDTH + 10;
  localparam int FINE_BITS   = 3;
  localparam int COARSE_GRAN = 1 << FINE_BITS;

  typedef struct packed {
    logic [ALIGN_WIDTH-1:0] sig;
    logic                   sticky;
    logic [EXP_WIDTH-1:0]   exp;
    logic                   eff_sub;
    logic                   c_exp_is_small;
    logic [FINE_BITS-1:0]   fine_amt;
  } align_payload_t;

endpackage

// File: rtl/align_shift_sticky.sv
// rtl/align_shift_sticky.sv - combinational logical right shift by amt*GRAN with shifted-out OR (ALIGN_STICKY_EN).
module align_shift_sticky #(
  parameter int WIDTH = 31,
  parameter int AMT_W = 3,
  parameter int GRAN  = 1
) (
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] out_data,
  output logic             sticky_out
);

  logic [31:0] sh;
  assign sh = 32'(amt) * 32'(GRAN);

  // Shifts at or beyond the datapath width flush everything into sticky.
  always_comb begin
    out_data = '0;
    if (sh < 32'(WIDTH)) out_data = in_data >> sh;
  end

`ifdef ALIGN_STICKY_EN
  logic [WIDTH-1:0] lost_mask;

  always_comb begin
    lost_mask = '1;
    if (sh < 32'(WIDTH)) lost_mask = ~({WIDTH{1'b1}} << sh);
  end

  assign sticky_out = |(in_data & lost_mask);
`else
  assign sticky_out = 1'b0;
`endif

endmodule

// File: rtl/addend_align_stage.sv
// rtl/addend_align_stage.sv - 2-stage addend alignment (coarse then fine shift) with valid/ready flow.
// Sticky generation is present only when ALIGN_STICKY_EN is defined.
module addend_align_stage
  import addend_align_stage_pkg::*;
#(
  parameter int EXP_WIDTH   = addend_align_stage_pkg::EXP_WIDTH,
  parameter int SIG_WIDTH   = addend_align_stage_pkg::SIG_WIDTH,
  parameter int SHAMT_WIDTH = addend_align_stage_pkg::SHAMT_WIDTH,
  localparam int ALIGN_WIDTH = 3 * SIG_WIDTH + 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SIG_WIDTH:0]     c_sig,
  input  logic                   eff_sub,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  input  logic [EXP_WIDTH-1:0]   res_exp,
  input  logic                   c_exp_is_small,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ALIGN_WIDTH-1:0] aligned_c,
  output logic                   sticky,
  output logic [EXP_WIDTH-1:0]   out_res_exp,
  output logic                   out_c_exp_is_small,
  output logic                   out_eff_sub
);

  align_payload_t s1_d, s1_q, s2_d, s2_q;
  logic           s1_valid_d, s1_valid_q, s2_valid_d, s2_valid_q;
  logic           s1_adv, s2_adv;

  logic [ALIGN_WIDTH-1:0] placed_sig, coarse_sig, fine_sig;
  logic                   coarse_sticky, fine_sticky;

  assign placed_sig = {c_sig, {(ALIGN_WIDTH-SIG_WIDTH-1){1'b0}}};

  align_shift_sticky #(
    .WIDTH (ALIGN_WIDTH),
    .AMT_W (SHAMT_WIDTH - FINE_BITS),
    .GRAN  (COARSE_GRAN)
  ) u_coarse (
    .in_data    (placed_sig),
    .amt        (shamt[SHAMT_WIDTH-1:FINE_BITS]),
    .out_data   (coarse_sig),
    .sticky_out (coarse_sticky)
  );

  align_shift_sticky #(
    .WIDTH (ALIGN_WIDTH),
    .AMT_W (FINE_BITS),
    .GRAN  (1)
  ) u_fine (
    .in_data    (s1_q.sig),
    .amt        (s1_q.fine_amt),
    .out_data   (fine_sig),
    .sticky_out (fine_sticky)
  );

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = s2_adv || !s1_valid_q;
  assign in_ready = s1_adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d.sig            = coarse_sig;
        s1_d.sticky         = coarse_sticky;
        s1_d.exp            = res_exp;
        s1_d.eff_sub        = eff_sub;
        s1_d.c_exp_is_small = c_exp_is_small;
        s1_d.fine_amt       = shamt[FINE_BITS-1:0];
      end
    end
  end

  // Inversion happens after the fine shift; the +1 is left to the adder's carry-in.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_d          = s1_q;
        s2_d.sig      = s1_q.eff_sub ? ~fine_sig : fine_sig;
        s2_d.sticky   = s1_q.sticky | fine_sticky;
        s2_d.fine_amt = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign out_valid          = s2_valid_q;
  assign aligned_c          = s2_q.sig;
  assign sticky             = s2_q.sticky;
  assign out_res_exp        = s2_q.exp;
  assign out_c_exp_is_small = s2_q.c_exp_is_small;
  assign out_eff_sub        = s2_q.eff_sub;

endmodule

// File: tb/tb_addend_align_stage.sv
// tb/tb_addend_align_stage.sv - directed self-checking bench for addend_align_stage.
module tb_addend_align_stage;

`ifdef ALIGN_STICKY_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  c_sig = '0;
  logic        eff_sub = 1'b0;
  logic [5:0]  shamt = '0;
  logic [7:0]  res_exp = '0;
  logic        c_exp_is_small = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [30:0] aligned_c;
  logic        sticky;
  logic [7:0]  out_res_exp;
  logic        out_c_exp_is_small;
  logic        out_eff_sub;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addend_align_stage dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .c_sig              (c_sig),
    .eff_sub            (eff_sub),
    .shamt              (shamt),
    .res_exp            (res_exp),
    .c_exp_is_small     (c_exp_is_small),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .aligned_c          (aligned_c),
    .sticky             (sticky),
    .out_res_exp        (out_res_exp),
    .out_c_exp_is_small (out_c_exp_is_small),
    .out_eff_sub        (out_eff_sub)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_handshake out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    checks++;
    if (aligned_c !== 31'h0 || sticky !== 1'b0 || out_res_exp !== 8'h0 ||
        out_c_exp_is_small !== 1'b0 || out_eff_sub !== 1'b0) begin
      errors++;
      $display("FAIL reset_data aligned_c=%h sticky=%b exp=%h small=%b esub=%b expected all 0",
               aligned_c, sticky, out_res_exp, out_c_exp_is_small, out_eff_sub);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_align_vectors();
    logic [7:0]  v_c   [9] = '{8'h80, 8'h81, 8'hFF, 8'hFF, 8'h81, 8'hC0, 8'h80, 8'h80, 8'h80};
    logic [5:0]  v_sh  [9] = '{6'd0, 6'd24, 6'd40, 6'd40, 6'd24, 6'd5, 6'd8, 6'd30, 6'd31};
    logic        v_es  [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [30:0] v_al  [9] = '{31'h40000000, 31'h00000040, 31'h00000000, 31'h7FFFFFFF,
                               31'h7FFFFFBF, 31'h03000000, 31'h00400000, 31'h00000001,
                               31'h00000000};
    logic        v_st  [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      c_sig = v_c[i]; shamt = v_sh[i]; eff_sub = v_es[i];
      res_exp = 8'(8'h10 + i); c_exp_is_small = i[0];
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL latency_early vec%0d out_valid=%b expected 0 one cycle after accept", i, out_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || aligned_c !== v_al[i] || sticky !== (v_st[i] & STICKY_ON) ||
          out_eff_sub !== v_es[i]) begin
        errors++;
        $display("FAIL align vec%0d valid=%b aligned_c=%h sticky=%b esub=%b expected 1/%h/%b/%b",
                 i, out_valid, aligned_c, sticky, out_eff_sub, v_al[i], v_st[i] & STICKY_ON, v_es[i]);
      end
    end
  endtask

  task automatic test_passthrough();
    out_ready = 1'b1;
    @(negedge clk);
    c_sig = 8'h80; shamt = 6'd0; eff_sub = 1'b0; res_exp = 8'h7F; c_exp_is_small = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    c_sig = 8'hC0; shamt = 6'd5; res_exp = 8'h22; c_exp_is_small = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_res_exp !== 8'h7F || out_c_exp_is_small !== 1'b1 ||
        aligned_c !== 31'h40000000) begin
      errors++;
      $display("FAIL passthru_a valid=%b exp=%h small=%b aligned_c=%h expected 1/7f/1/40000000",
               out_valid, out_res_exp, out_c_exp_is_small, aligned_c);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_res_exp !== 8'h22 || out_c_exp_is_small !== 1'b0 ||
        aligned_c !== 31'h03000000) begin
      errors++;
      $display("FAIL passthru_b valid=%b exp=%h small=%b aligned_c=%h expected 1/22/0/03000000",
               out_valid, out_res_exp, out_c_exp_is_small, aligned_c);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0]  o_c  [4] = '{8'h80, 8'hC0, 8'h80, 8'h81};
    logic [5:0]  o_sh [4] = '{6'd0, 6'd5, 6'd30, 6'd24};
    logic        o_es [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [30:0] o_al [4] = '{31'h40000000, 31'h03000000, 31'h00000001, 31'h7FFFFFBF};
    logic        o_st [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int sent = 0;
    int recv = 0;
    logic [30:0] held_al = '0;
    logic [7:0]  held_exp = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 2 && cyc <= 4);
      in_valid  = (sent < 4);
      if (sent < 4) begin
        c_sig = o_c[sent]; shamt = o_sh[sent]; eff_sub = o_es[sent];
        res_exp = 8'(8'h40 + sent); c_exp_is_small = 1'b0;
      end
      #1;
      if (cyc == 2) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL b2b_stall_ready in_ready=%b out_valid=%b expected 0/1", in_ready, out_valid);
        end
        held_al = aligned_c;
        held_exp = out_res_exp;
      end
      if (cyc == 3 || cyc == 4) begin
        checks++;
        if (aligned_c !== held_al || out_res_exp !== held_exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_hold cyc%0d aligned_c=%h exp=%h valid=%b in_ready=%b expected %h/%h/1/0",
                   cyc, aligned_c, out_res_exp, out_valid, in_ready, held_al, held_exp);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (recv >= 4) begin
          errors++;
          $display("FAIL b2b_extra output aligned_c=%h expected none (recv=%0d)", aligned_c, recv);
        end else if (aligned_c !== o_al[recv] || sticky !== (o_st[recv] & STICKY_ON) ||
                     out_res_exp !== 8'(8'h40 + recv)) begin
          errors++;
          $display("FAIL b2b_out%0d aligned_c=%h sticky=%b exp=%h expected %h/%b/%h", recv,
                   aligned_c, sticky, out_res_exp, o_al[recv], o_st[recv] & STICKY_ON, 8'(8'h40 + recv));
        end
        recv++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (recv != 4 || sent != 4) begin
      errors++;
      $display("FAIL b2b_count received=%0d sent=%0d expected 4/4", recv, sent);
    end
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    out_ready = 1'b1;
    @(negedge clk);
    c_sig = 8'h80; shamt = 6'd0; eff_sub = 1'b0; res_exp = 8'h55;
    in_valid = 1'b1;
    @(negedge clk);
    c_sig = 8'hFF; shamt = 6'd3; res_exp = 8'h66;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || aligned_c !== 31'h0 || out_res_exp !== 8'h0) begin
      errors++;
      $display("FAIL rst_mid out_valid=%b in_ready=%b aligned_c=%h exp=%h expected 0/1/0/0",
               out_valid, in_ready, aligned_c, out_res_exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL rst_stale stale_outputs=%0d expected 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_align_vectors();
    test_passthrough();
    test_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout simulation exceeded bound");
    $fatal(1, "timeout");
  end

endmodule
